// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial arithmetic blocks.
package serial_arith_pkg;

    localparam int SUB_DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } sub_state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: the single arithmetic cell reused every clock by the serial subtractor.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic borrow_in,
    output logic diff,
    output logic borrow_out
);

    assign diff       = a ^ b ^ borrow_in;
    assign borrow_out = (~a & b) | (~(a ^ b) & borrow_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first unsigned subtractor: diff = a - b - borrow_in, one bit per clock,
// with valid/ready handshakes on both operand and result sides.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = SUB_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    sub_state_t       state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] d_sr_q, d_sr_d;
    logic             brw_q, brw_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;

    logic             fs_diff;
    logic             fs_borrow;
    logic [WIDTH-1:0] d_shift;

    full_subtractor u_fs (
        .a          (a_sr_q[0]),
        .b          (b_sr_q[0]),
        .borrow_in  (brw_q),
        .diff       (fs_diff),
        .borrow_out (fs_borrow)
    );

    // New difference bit enters at the MSB so the LSB-first stream lands in order.
    generate
        if (WIDTH == 1) begin : g_w1
            assign d_shift = fs_diff;
        end else begin : g_wn
            assign d_shift = {fs_diff, d_sr_q[WIDTH-1:1]};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        d_sr_d  = d_sr_q;
        brw_d   = brw_q;
        cnt_d   = cnt_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    brw_d   = borrow_in;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                d_sr_d = d_shift;
                brw_d  = fs_borrow;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    diff_d  = d_shift;
                    bout_d  = fs_borrow;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            d_sr_q  <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            d_sr_q  <= d_sr_d;
            brw_q   <= brw_d;
            cnt_q   <= cnt_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign diff       = diff_q;
    assign borrow_out = bout_q;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial, LSB-first unsigned subtractor: diff = a - b - borrow_in, one bit per clock through a single full-subtractor cell.
- Area-cheap counterpart to the parallel ripple adder in the basics library; used where subtraction is infrequent and latency is tolerable.
- Operands are taken in and results returned over valid/ready handshakes.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range is 1 or more.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands a, b and borrow_in are valid
- in_ready  output  1  block can accept operands (high only in S_IDLE)
- a  input  WIDTH  minuend, unsigned
- b  input  WIDTH  subtrahend, unsigned
- borrow_in  input  1  incoming borrow
- out_valid  output  1  diff and borrow_out are valid (high only in S_DONE)
- out_ready  input  1  consumer accepts the result
- diff  output  WIDTH  (a - b - borrow_in) mod 2^WIDTH
- borrow_out  output  1  1 iff a < b + borrow_in (unsigned compare)
- busy  output  1  high in S_RUN or S_DONE

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state S_IDLE, in_ready 1, out_valid 0, busy 0, diff 0, borrow_out 0, all internal shift registers, counter and borrow register 0.
- S_IDLE:
  - in_ready=1.
  - On in_valid & in_ready at edge k, capture a into a_sr, b into b_sr and borrow_in into brw; clear cnt; go to S_RUN.
- S_RUN:
  - Each edge, the full-subtractor takes a_sr[0], b_sr[0] and brw.
  - The difference bit shifts into the MSB of d_sr (right shift); the borrow bit is written to brw.
  - a_sr and b_sr shift right by one; cnt increments.
  - When cnt == WIDTH-1 at an edge, that is the final bit: go to S_DONE.
- S_RUN timing: processing occupies edges k+1 through k+WIDTH. On edge k+WIDTH, diff is loaded from the completed d_sr and borrow_out from the final borrow.
- S_DONE:
  - out_valid=1.
  - diff and borrow_out stay stable while out_ready is low, for any length of backpressure.
  - On out_valid & out_ready, go to S_IDLE.
- Latency: out_valid is first high in the cycle after edge k+WIDTH, i.e. WIDTH cycles after the accepting edge.
- Throughput: one operation per WIDTH+2 cycles with out_ready tied high. No overlap of operations.
- Handshake rules:
  - in_ready is low in S_RUN and S_DONE; in_valid is ignored there and a, b and borrow_in may change freely.
  - Input and output handshakes can never occur in the same cycle.
- diff and borrow_out hold their last result after the output handshake until the next completion. They are meaningful only while out_valid is high.
- cnt width is $clog2(WIDTH+1).
- WIDTH=1: a single S_RUN cycle; same rules apply.
- Reset in any state, including mid-S_RUN or S_DONE, aborts the operation:
  - the next cycle shows reset values;
  - no partial result is presented.
- rst has priority over all handshakes in the same cycle.

Decomposition:
- Shared package serial_arith_pkg:
  - typedef enum logic [1:0] sub_state_t {S_IDLE, S_RUN, S_DONE};
  - constant SUB_DEFAULT_WIDTH = 8.
- One sub-module, full_subtractor, purely combinational, instantiated once.
  - Ports: a, b, borrow_in, diff, borrow_out.
  - diff = a^b^borrow_in.
  - borrow_out = (~a & b) | (~(a^b) & borrow_in).

Test Plan:
- 0x5A - 0x3C, borrow_in 0, out_ready 1 -> diff 0x1E, borrow_out 0; out_valid first high exactly 8 cycles after the accept edge and high for 1 cycle.
- 0x00 - 0x01, borrow_in 0 -> diff 0xFF, borrow_out 1.
- 0x80 - 0x7F, borrow_in 1 -> diff 0x00, borrow_out 0. Also 0x00 - 0x00, borrow_in 1 -> 0xFF, borrow_out 1.
- Backpressure case, 0x10 - 0x01 with out_ready low for 5 cycles:
  - out_valid, diff=0x0F and borrow_out=0 are stable throughout;
  - in_ready stays 0 and in_valid pulses are ignored;
  - release out_ready -> in_ready=1 on the next cycle.
- Assert rst for 1 cycle after 4 S_RUN bits:
  - next cycle: in_ready 1, out_valid 0, busy 0, diff 0;
  - a following 0xFF - 0x01 -> 0xFE, borrow_out 0.
- 1000 random vectors, back-to-back with in_valid and out_ready held high, checked against a reference model:
  - accepts are spaced exactly WIDTH+2 = 10 cycles apart;
  - repeat the run with WIDTH=1 and WIDTH=16.
